// File: rtl/color_track.sv
// Chroma-threshold pixel classifier with per-pixel temporal history and a
// per-frame bounding box / hit counter of temporally stable hits.
module color_track #(
    parameter int unsigned HIST_DEPTH = 4,
    parameter int unsigned CMP_MODE   = 0,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned HW         = $clog2(HIST_DEPTH + 1),
    parameter int unsigned CW         = $clog2(H_ACTIVE * V_ACTIVE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  color_valid,
    input  logic [7:0]            Cb,
    input  logic [7:0]            Cr,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic [HIST_DEPTH-1:0] color_history,
    input  logic [7:0]            thr_lo_Cb,
    input  logic [7:0]            thr_lo_Cr,
    input  logic [7:0]            thr_hi_Cb,
    input  logic [7:0]            thr_hi_Cr,
    input  logic [HW-1:0]         threshold_history,
    output logic                  corner_detected,
    output logic [HIST_DEPTH-1:0] updated_color_history,
    output logic                  we,
    output logic [9:0]            write_x,
    output logic [9:0]            write_y,
    output logic                  box_valid,
    output logic                  box_found,
    output logic [9:0]            box_left,
    output logic [9:0]            box_right,
    output logic [9:0]            box_top,
    output logic [9:0]            box_bottom,
    output logic [CW-1:0]         hit_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [9:0] LastX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LastY = 10'(V_ACTIVE - 1);

    state_e                state_q;
    logic                  hit;
    logic [HW-1:0]         pop;
    logic [HIST_DEPTH-1:0] hist_next;
    logic [9:0]            acc_left, acc_right, acc_top, acc_bottom;
    logic [CW-1:0]         acc_count;
    logic                  last_pixel;

    always_comb begin
        if (CMP_MODE == 0) begin
            hit = (Cb < thr_lo_Cb) && (Cr < thr_lo_Cr);
        end else begin
            hit = (Cb >= thr_lo_Cb) && (Cb <= thr_hi_Cb) &&
                  (Cr >= thr_lo_Cr) && (Cr <= thr_hi_Cr);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            pop = pop + HW'(color_history[i]);
        end
    end

    generate
        if (HIST_DEPTH == 1) begin : g_hist1
            assign hist_next = hit;
        end else begin : g_histn
            assign hist_next = {color_history[HIST_DEPTH-2:0], hit};
        end
    endgenerate

    // Stage 1: SRAM write-back and stability flag, independent of the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we                    <= 1'b0;
            corner_detected       <= 1'b0;
            write_x               <= '0;
            write_y               <= '0;
            updated_color_history <= '0;
        end else if (color_valid) begin
            we                    <= 1'b1;
            corner_detected       <= hit && (pop > threshold_history);
            write_x               <= x;
            write_y               <= y;
            updated_color_history <= hist_next;
        end else begin
            we              <= 1'b0;
            corner_detected <= 1'b0;
        end
    end

    assign last_pixel = we && (write_x == LastX) && (write_y == LastY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            acc_left   <= '1;
            acc_right  <= '0;
            acc_top    <= '1;
            acc_bottom <= '0;
            acc_count  <= '0;
            box_valid  <= 1'b0;
            box_found  <= 1'b0;
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            hit_count  <= '0;
        end else begin
            box_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        state_q    <= StAccum;
                        acc_left   <= '1;
                        acc_right  <= '0;
                        acc_top    <= '1;
                        acc_bottom <= '0;
                        acc_count  <= '0;
                    end
                end
                StAccum: begin
                    // A restart discards the partial frame; clearing beats a pending hit.
                    if (frame_start) begin
                        acc_left   <= '1;
                        acc_right  <= '0;
                        acc_top    <= '1;
                        acc_bottom <= '0;
                        acc_count  <= '0;
                    end else begin
                        if (corner_detected) begin
                            if (write_x < acc_left)   acc_left   <= write_x;
                            if (write_x > acc_right)  acc_right  <= write_x;
                            if (write_y < acc_top)    acc_top    <= write_y;
                            if (write_y > acc_bottom) acc_bottom <= write_y;
                            if (acc_count != {CW{1'b1}}) acc_count <= acc_count + CW'(1);
                        end
                        if (last_pixel) state_q <= StDone;
                    end
                end
                StDone: begin
                    box_valid  <= 1'b1;
                    box_found  <= (acc_count != '0);
                    box_left   <= acc_left;
                    box_right  <= acc_right;
                    box_top    <= acc_top;
                    box_bottom <= acc_bottom;
                    hit_count  <= acc_count;
                    if (frame_start) begin
                        state_q    <= StAccum;
                        acc_left   <= '1;
                        acc_right  <= '0;
                        acc_top    <= '1;
                        acc_bottom <= '0;
                        acc_count  <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_color_track.sv
// Directed bench for color_track: a compare-mode-0 and a compare-mode-1 instance
// share stimulus; table-driven stage-1 vectors plus frame/reset sequences.
module tb_color_track;

    localparam int unsigned CW = $clog2(640 * 480 + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          color_valid;
    logic [7:0]    Cb, Cr;
    logic [9:0]    x, y;
    logic [3:0]    color_history;
    logic [7:0]    thr_lo_Cb, thr_lo_Cr, thr_hi_Cb, thr_hi_Cr;
    logic [2:0]    threshold_history;

    logic          corner0, we0, bv0, bf0;
    logic [3:0]    upd0;
    logic [9:0]    wx0, wy0, bl0, br0, bt0, bb0;
    logic [CW-1:0] cnt0;
    logic          corner1, we1, bv1, bf1;
    logic [3:0]    upd1;
    logic [9:0]    wx1, wy1, bl1, br1, bt1, bb1;
    logic [CW-1:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    color_track #(.HIST_DEPTH(4), .CMP_MODE(0)) u0 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .color_valid(color_valid),
        .Cb(Cb), .Cr(Cr), .x(x), .y(y), .color_history(color_history),
        .thr_lo_Cb(thr_lo_Cb), .thr_lo_Cr(thr_lo_Cr), .thr_hi_Cb(thr_hi_Cb),
        .thr_hi_Cr(thr_hi_Cr), .threshold_history(threshold_history),
        .corner_detected(corner0), .updated_color_history(upd0), .we(we0),
        .write_x(wx0), .write_y(wy0), .box_valid(bv0), .box_found(bf0),
        .box_left(bl0), .box_right(br0), .box_top(bt0), .box_bottom(bb0), .hit_count(cnt0)
    );

    color_track #(.HIST_DEPTH(4), .CMP_MODE(1)) u1 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .color_valid(color_valid),
        .Cb(Cb), .Cr(Cr), .x(x), .y(y), .color_history(color_history),
        .thr_lo_Cb(thr_lo_Cb), .thr_lo_Cr(thr_lo_Cr), .thr_hi_Cb(thr_hi_Cb),
        .thr_hi_Cr(thr_hi_Cr), .threshold_history(threshold_history),
        .corner_detected(corner1), .updated_color_history(upd1), .we(we1),
        .write_x(wx1), .write_y(wy1), .box_valid(bv1), .box_found(bf1),
        .box_left(bl1), .box_right(br1), .box_top(bt1), .box_bottom(bb1), .hit_count(cnt1)
    );

    typedef struct {
        logic [7:0] cb, cr, lo_cb, lo_cr, hi_cb, hi_cr;
        logic [3:0] hist;
        logic [2:0] thr;
        logic       c0;
        logic [3:0] u0;
        logic       c1;
        logic [3:0] u1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one pixel (hit uses mode-0 friendly chroma) and advance to next negedge.
    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic is_hit);
        color_valid = 1'b1;
        frame_start = 1'b0;
        x  = px;
        y  = py;
        Cb = is_hit ? 8'd40 : 8'd200;
        Cr = 8'd50;
        @(negedge clk);
        color_valid = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        color_valid = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_box0(input string tag, input logic f, input logic [9:0] l,
                              input logic [9:0] r, input logic [9:0] t, input logic [9:0] b,
                              input int unsigned c);
        check({tag, "_found"}, 32'(bf0), 32'(f));
        check({tag, "_left"}, 32'(bl0), 32'(l));
        check({tag, "_right"}, 32'(br0), 32'(r));
        check({tag, "_top"}, 32'(bt0), 32'(t));
        check({tag, "_bottom"}, 32'(bb0), 32'(b));
        check({tag, "_count"}, 32'(cnt0), c);
    endtask

    initial begin
        vecs[0] = '{8'd40, 8'd50, 8'd80, 8'd80, 8'd255, 8'd255, 4'b0111, 3'd2,
                    1'b1, 4'b1111, 1'b0, 4'b1110};
        vecs[1] = '{8'd40, 8'd50, 8'd80, 8'd80, 8'd255, 8'd255, 4'b0011, 3'd2,
                    1'b0, 4'b0111, 1'b0, 4'b0110};
        vecs[2] = '{8'd100, 8'd60, 8'd60, 8'd60, 8'd100, 8'd100, 4'b0111, 3'd2,
                    1'b0, 4'b1110, 1'b1, 4'b1111};
        vecs[3] = '{8'd101, 8'd60, 8'd60, 8'd60, 8'd100, 8'd100, 4'b0111, 3'd2,
                    1'b0, 4'b1110, 1'b0, 4'b1110};
        vecs[4] = '{8'd80, 8'd10, 8'd80, 8'd80, 8'd255, 8'd255, 4'b1111, 3'd3,
                    1'b0, 4'b1110, 1'b0, 4'b1110};
        vecs[5] = '{8'd79, 8'd79, 8'd80, 8'd80, 8'd255, 8'd255, 4'b1111, 3'd3,
                    1'b1, 4'b1111, 1'b0, 4'b1110};
        vecs[6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 4'b1111, 3'd4,
                    1'b0, 4'b1111, 1'b0, 4'b1110};
        vecs[7] = '{8'd60, 8'd100, 8'd60, 8'd60, 8'd100, 8'd100, 4'b1000, 3'd0,
                    1'b0, 4'b0000, 1'b1, 4'b0001};

        reset = 1'b0;
        frame_start = 1'b0;
        color_valid = 1'b0;
        Cb = '0; Cr = '0; x = '0; y = '0;
        color_history = '0;
        thr_lo_Cb = '0; thr_lo_Cr = '0; thr_hi_Cb = '0; thr_hi_Cr = '0;
        threshold_history = '0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(we0), 0);
        check("rst_corner", 32'(corner0), 0);
        check("rst_box_valid", 32'(bv0), 0);
        check_box0("rst", 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 0);
        reset = 1'b1;
        @(negedge clk);

        // Stage-1 vectors
        for (int i = 0; i < 8; i++) begin
            Cb = vecs[i].cb; Cr = vecs[i].cr;
            thr_lo_Cb = vecs[i].lo_cb; thr_lo_Cr = vecs[i].lo_cr;
            thr_hi_Cb = vecs[i].hi_cb; thr_hi_Cr = vecs[i].hi_cr;
            color_history = vecs[i].hist;
            threshold_history = vecs[i].thr;
            x = 10'(3 * i + 1);
            y = 10'(i + 2);
            color_valid = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_we", i), 32'(we0), 1);
            check($sformatf("v%0d_wx", i), 32'(wx0), 32'(3 * i + 1));
            check($sformatf("v%0d_wy", i), 32'(wy0), 32'(i + 2));
            check($sformatf("v%0d_corner0", i), 32'(corner0), 32'(vecs[i].c0));
            check($sformatf("v%0d_upd0", i), 32'(upd0), 32'(vecs[i].u0));
            check($sformatf("v%0d_corner1", i), 32'(corner1), 32'(vecs[i].c1));
            check($sformatf("v%0d_upd1", i), 32'(upd1), 32'(vecs[i].u1));
        end
        color_valid = 1'b0;
        @(negedge clk);
        check("idle_we", 32'(we0), 0);
        check("idle_corner1", 32'(corner1), 0);
        check("idle_upd_hold", 32'(upd1), 32'(4'b0001));
        check("idle_wx_hold", 32'(wx0), 32'd22);

        // Frame with three stable hits in u0; u1 sees none of them.
        thr_lo_Cb = 8'd80; thr_lo_Cr = 8'd80; thr_hi_Cb = 8'd255; thr_hi_Cr = 8'd255;
        color_history = 4'b0111;
        threshold_history = 3'd2;
        fs();
        pix(10'd10, 10'd20, 1'b1);
        pix(10'd100, 10'd100, 1'b0);
        pix(10'd300, 10'd5, 1'b1);
        pix(10'd639, 10'd479, 1'b1);
        check("f1_bv_e0", 32'(bv0), 0);
        @(negedge clk);
        check("f1_bv_e1", 32'(bv0), 0);
        @(negedge clk);
        check("f1_bv_e2", 32'(bv0), 1);
        check_box0("f1", 1'b1, 10'd10, 10'd639, 10'd5, 10'd479, 3);
        check("f1_u1_bv", 32'(bv1), 1);
        check("f1_u1_found", 32'(bf1), 0);
        check("f1_u1_left", 32'(bl1), 32'h3FF);
        check("f1_u1_top", 32'(bt1), 32'h3FF);
        check("f1_u1_right", 32'(br1), 0);
        check("f1_u1_bottom", 32'(bb1), 0);
        check("f1_u1_count", 32'(cnt1), 0);
        @(negedge clk);
        check("f1_bv_pulse_end", 32'(bv0), 0);
        check_box0("f1_hold", 1'b1, 10'd10, 10'd639, 10'd5, 10'd479, 3);

        // Restart mid-frame; restart edge coincides with a stage-1 hit.
        fs();
        pix(10'd10, 10'd20, 1'b1);
        pix(10'd50, 10'd60, 1'b1);
        fs();
        check("f2_restart_no_bv", 32'(bv0), 0);
        pix(10'd200, 10'd100, 1'b1);
        pix(10'd639, 10'd479, 1'b0);
        @(negedge clk);
        check("f2_bv_e1", 32'(bv0), 0);
        @(negedge clk);
        check("f2_bv_e2", 32'(bv0), 1);
        check_box0("f2", 1'b1, 10'd200, 10'd200, 10'd100, 10'd100, 1);

        // Reset while streaming a frame
        fs();
        pix(10'd10, 10'd20, 1'b1);
        color_valid = 1'b1; x = 10'd5; y = 10'd5; Cb = 8'd40;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(we0), 0);
        check("mid_rst_corner", 32'(corner0), 0);
        check("mid_rst_wx", 32'(wx0), 0);
        check("mid_rst_upd", 32'(upd0), 0);
        check_box0("mid_rst", 1'b0, 10'd0, 10'd0, 10'd0, 10'd0, 0);
        @(negedge clk);
        color_valid = 1'b0;
        reset = 1'b1;
        pix(10'd639, 10'd479, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_rst_no_bv%0d", i), 32'(bv0), 0);
            @(negedge clk);
        end
        fs();
        pix(10'd639, 10'd479, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("f3_bv", 32'(bv0), 1);
        check_box0("f3", 1'b1, 10'd639, 10'd639, 10'd479, 10'd479, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
